// File: rtl/axi_wr_arb_pkg.sv
// Shared types and constants for the two-port AXI4 write-channel arbiter.
package axi_wr_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 8;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

endpackage

// File: rtl/axi_wr_arbiter_rr_arb2.sv
// Two-way round-robin pick: a tie goes to the port that did not win last time.
module rr_arb2
    import axi_wr_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Shares one AXI4 master write port between two burst writers, holding the
// grant from address phase through write response.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | waiting for awvalid; picks a port and latches addr/len
//   ADDR    | presenting latched address on m_aw*, waiting m_awready
//   DATA    | forwarding the granted port's W beats, counting down
//   RESP    | m_bready high, waiting for m_bvalid
module axi_wr_arbiter
    import axi_wr_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req0_awvalid,
    input  logic [ADDR_W-1:0]   req0_awaddr,
    input  logic [LEN_W-1:0]    req0_awlen,
    output logic                req0_awready,
    input  logic                req0_wvalid,
    input  logic [DATA_W-1:0]   req0_wdata,
    input  logic [DATA_W/8-1:0] req0_wstrb,
    output logic                req0_wready,
    output logic                req0_bvalid,

    input  logic                req1_awvalid,
    input  logic [ADDR_W-1:0]   req1_awaddr,
    input  logic [LEN_W-1:0]    req1_awlen,
    output logic                req1_awready,
    input  logic                req1_wvalid,
    input  logic [DATA_W-1:0]   req1_wdata,
    input  logic [DATA_W/8-1:0] req1_wstrb,
    output logic                req1_wready,
    output logic                req1_bvalid,

    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [LEN_W-1:0]    m_awlen,
    output logic [1:0]          m_awburst,
    output logic [2:0]          m_awsize,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    output logic                m_wlast,
    input  logic                m_wready,
    input  logic                m_bvalid,
    output logic                m_bready
);

    arb_state_e         state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [LEN_W-1:0]   beats_left_q, beats_left_d;
    logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
    logic [LEN_W-1:0]   awlen_q, awlen_d;

    logic               pick;
    logic               w_last;
    logic               w_hs;

    rr_arb2 u_rr_arb2 (
        .req        ({req1_awvalid, req0_awvalid}),
        .last_grant (last_grant_q),
        .grant      (pick)
    );

    assign m_awburst = AXI_BURST_INCR;
    assign m_awsize  = AXI_SIZE_4B;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beats_left_q <= '0;
            awaddr_q     <= '0;
            awlen_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beats_left_q <= beats_left_d;
            awaddr_q     <= awaddr_d;
            awlen_q      <= awlen_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beats_left_d = beats_left_q;
        awaddr_d     = awaddr_q;
        awlen_d      = awlen_q;

        m_awvalid    = 1'b0;
        m_awaddr     = '0;
        m_awlen      = '0;
        m_wvalid     = 1'b0;
        m_wdata      = '0;
        m_wstrb      = '0;
        m_wlast      = 1'b0;
        m_bready     = 1'b0;
        req0_awready = 1'b0;
        req1_awready = 1'b0;
        req0_wready  = 1'b0;
        req1_wready  = 1'b0;
        req0_bvalid  = 1'b0;
        req1_bvalid  = 1'b0;

        w_last       = (beats_left_q == '0);
        w_hs         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req0_awvalid || req1_awvalid) begin
                    grant_d  = pick;
                    awaddr_d = pick ? req1_awaddr : req0_awaddr;
                    awlen_d  = pick ? req1_awlen  : req0_awlen;
                    state_d  = ST_ADDR;
                end
            end

            ST_ADDR: begin
                m_awvalid    = 1'b1;
                m_awaddr     = awaddr_q;
                m_awlen      = awlen_q;
                req0_awready = m_awready && !grant_q;
                req1_awready = m_awready &&  grant_q;
                if (m_awready) begin
                    beats_left_d = awlen_q;
                    state_d      = ST_DATA;
                end
            end

            ST_DATA: begin
                m_wvalid    = grant_q ? req1_wvalid : req0_wvalid;
                m_wdata     = grant_q ? req1_wdata  : req0_wdata;
                m_wstrb     = grant_q ? req1_wstrb  : req0_wstrb;
                m_wlast     = w_last;
                req0_wready = m_wready && !grant_q;
                req1_wready = m_wready &&  grant_q;
                w_hs        = m_wvalid && m_wready;
                // Stop counting on the last beat so a 256-beat burst never wraps.
                if (w_hs) begin
                    if (w_last) begin
                        state_d = ST_RESP;
                    end else begin
                        beats_left_d = beats_left_q - LEN_W'(1);
                    end
                end
            end

            ST_RESP: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    req0_bvalid  = !grant_q;
                    req1_bvalid  =  grant_q;
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Two-port AXI4 write-channel arbiter that shares one AXI master write port (AW/W/B) between two HLS-generated burst writers. It grants one requester at a time and holds the grant from address acceptance through the write response. Grants alternate round-robin when both requesters are pending. It sits between the kernels' `s_axi_*` write outputs and the single memory-side AXI slave.

## Interface
- ADDR_W, 16, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- LEN_W, 8, burst length field width (beats = len+1)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req0_awvalid / req1_awvalid  in  1  burst request
- req0_awaddr / req1_awaddr  in  ADDR_W  burst start address
- req0_awlen / req1_awlen  in  LEN_W  beats minus one
- req0_awready / req1_awready  out  1  address accepted (granted port only)
- req0_wvalid / req1_wvalid  in  1  write beat valid
- req0_wdata / req1_wdata  in  DATA_W  beat data
- req0_wstrb / req1_wstrb  in  DATA_W/8  byte strobes
- req0_wready / req1_wready  out  1  beat accepted
- req0_bvalid / req1_bvalid  out  1  one-cycle burst-complete pulse
- m_awaddr  out  ADDR_W; m_awlen  out  LEN_W; m_awburst  out  2 (constant 2'b01 INCR); m_awsize  out  3 (constant 3'b010, 4 bytes)
- m_awvalid  out  1; m_awready  in  1
- m_wdata  out  DATA_W; m_wstrb  out  DATA_W/8; m_wvalid  out  1; m_wlast  out  1; m_wready  in  1
- m_bvalid  in  1; m_bready  out  1

## Operation
- FSM states: IDLE, ADDR, DATA, RESP. Registers: `grant` (1 bit), `last_grant` (1 bit), `beats_left` (LEN_W), latched `awaddr` and `awlen`.
- IDLE: no requests pending -> stay. Exactly one awvalid -> grant that port. Both -> grant `!last_grant`. Latch the granted addr/len. Go to ADDR.
- ADDR: m_awvalid=1 with the latched addr/len. reqN_awready = m_awready for the granted port (combinational), 0 for the other port. On m_awready, load beats_left=awlen and go to DATA.
- DATA: m_wvalid/m_wdata/m_wstrb are muxed from the granted port. reqN_wready = m_wready for the granted port only. m_wlast = (beats_left==0). On a handshake (m_wvalid&&m_wready), decrement beats_left. When that handshake carries wlast, go to RESP.
- RESP: m_bready=1. On m_bvalid, pulse reqN_bvalid for the granted port in the same cycle, set last_grant=grant, go to IDLE.
- Requesters hold awvalid/addr/len stable until awready (AXI rule). The arbiter does not re-sample them after the IDLE latch.
- Ungranted port: awready, wready and bvalid all 0. Its wvalid is ignored.
- Outside ADDR, m_awaddr/m_awlen = 0. Outside DATA, m_wdata/m_wstrb = 0 and m_wlast = 0.

## Timing
- Reset: state=IDLE, last_grant=1 (port 0 wins the first tie), beats_left=0. All valid/ready outputs 0, all data outputs 0. m_awburst=2'b01 and m_awsize=3'b010 at all times.
- Request-to-m_awvalid latency: 1 cycle (request seen in IDLE, m_awvalid in the next cycle).
- Minimum burst occupancy with zero-wait slave: 1 (IDLE) + 1 (ADDR) + (len+1) (DATA) + 1 (RESP) cycles.
- Back-to-back bursts: after leaving RESP, at least one IDLE cycle separates grants.
- awlen=0: a single beat with m_wlast=1 on the first beat. awlen=255: 256 beats, and beats_left must not wrap before wlast.
- m_wvalid low or m_wready low in DATA: beats_left holds and no state change.
- rst asserted mid-burst: immediate return to IDLE. Outstanding bursts are abandoned. Next cycle matches the reset state.
- m_bvalid is only honoured in RESP.

## Structure
- Package `axi_wr_arb_pkg`: state enum, AXI_BURST_INCR=2'b01, AXI_SIZE_4B=3'b010, default width constants.
- Sub-module `rr_arb2`: combinational 2-way round-robin pick (inputs: req[1:0], last_grant; output: grant). The rest is flat.

## Test plan
- After reset, req0 only, addr 0x0100, len 3, 4 beats 0xA0..0xA3, zero-wait slave -> m_awvalid in cycle 2, four beats, m_wlast on 0xA3, one req0_bvalid pulse when m_bvalid arrives.
- req0 and req1 asserted in the same cycle straight after reset -> req0 is granted first, req1 second (addr 0x0200); a second tie then goes to req0 again.
- len=0 on req1 with m_wready low for 3 cycles -> m_wvalid is held, m_wlast=1 on the single beat, req0_wready stays 0 throughout.
- len=255 burst -> exactly 256 beat handshakes and m_wlast only on the 256th.
- m_bvalid delayed 5 cycles in RESP -> m_bready stays high, no new m_awvalid until the response arrives.
- rst pulsed after the 2nd beat of a 4-beat burst -> all outputs 0 the next cycle; a fresh req1 request is served correctly.
